// File: rtl/bus_trace_buffer.sv
// Passive system-bus observer. Qualifying bus cycles go into a circular trace RAM.
// Capture stops a programmable number of entries after an address trigger; the window is read back through a registered port.
module bus_trace_buffer #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int ADDR_WIDTH  = 12,
  parameter  int DEPTH       = 16,
  parameter  int COUNT_WIDTH = 16,
  localparam int IW          = $clog2(DEPTH),
  localparam int CW          = IW + 1,
  localparam int EW          = ADDR_WIDTH + DATA_WIDTH + 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  dataBus,
  input  logic [ADDR_WIDTH-1:0]  addressBus,
  input  logic                   write,
  input  logic                   sync,
  input  logic                   arm,
  input  logic [1:0]             capture_mode,
  input  logic [ADDR_WIDTH-1:0]  trigger_address,
  input  logic                   trigger_on_write,
  input  logic [CW-1:0]          post_trigger,
  input  logic                   read_request,
  input  logic [IW-1:0]          read_index,
  output logic                   armed,
  output logic                   triggered,
  output logic                   done,
  output logic                   wrapped,
  output logic [CW-1:0]          entry_count,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic                   read_valid,
  output logic [EW-1:0]          read_data
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARMED     = 2'd1,
    S_TRIGGERED = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          remaining_q, remaining_d;
  logic                   wrapped_q, wrapped_d;
  logic                   triggered_q, triggered_d;
  logic [COUNT_WIDTH-1:0] cycle_q, cycle_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   rd_zero_q, rd_zero_d;

  logic [EW-1:0]          mem_q [DEPTH];
  logic [EW-1:0]          rd_word_q;

  logic                   qualify;
  logic                   hit;
  logic                   capturing;
  logic                   wr_en;
  logic [CW-1:0]          post_eff;
  logic [IW-1:0]          rd_addr;
  logic [EW-1:0]          wr_word;

  always_comb begin
    qualify = 1'b0;
    case (capture_mode)
      2'd0:    qualify = 1'b1;
      2'd1:    qualify = write;
      2'd2:    qualify = sync;
      default: qualify = write | sync;
    endcase
  end

  assign hit       = qualify && (addressBus == trigger_address) && (write || !trigger_on_write);
  assign capturing = (state_q == S_ARMED) || (state_q == S_TRIGGERED);
  // The arm cycle restarts the trace, so its own bus value is never recorded.
  assign wr_en     = capturing && qualify && !arm && !reset;
  assign wr_word   = {sync, write, addressBus, dataBus};

  always_comb begin
    post_eff = post_trigger;
    if (post_trigger == '0) begin
      post_eff = CW'(1);
    end else if (post_trigger > CW'(DEPTH)) begin
      post_eff = CW'(DEPTH);
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = S_ARMED;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (wr_en && hit) begin
            state_d = (post_eff == CW'(1)) ? S_DONE : S_TRIGGERED;
          end
        end
        S_TRIGGERED: begin
          if (wr_en && (remaining_q == CW'(1))) begin
            state_d = S_DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Output logic
  always_comb begin
    armed = (state_q == S_ARMED) || (state_q == S_TRIGGERED);
    done  = (state_q == S_DONE);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    wrapped_d   = wrapped_q;
    triggered_d = triggered_q;
    cycle_d     = cycle_q;
    if (arm) begin
      wr_ptr_d    = '0;
      count_d     = '0;
      remaining_d = '0;
      wrapped_d   = 1'b0;
      triggered_d = 1'b0;
      cycle_d     = '0;
    end else begin
      if (capturing && (cycle_q != '1)) begin
        cycle_d = cycle_q + 1'b1;
      end
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (count_q == CW'(DEPTH)) begin
          wrapped_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
        if ((state_q == S_ARMED) && hit) begin
          triggered_d = 1'b1;
          remaining_d = post_eff - 1'b1;
        end else if (state_q == S_TRIGGERED) begin
          remaining_d = remaining_q - 1'b1;
        end
      end
    end
  end

  // The oldest entry sits entry_count slots behind the write pointer.
  assign rd_addr = wr_ptr_q - count_q[IW-1:0] + read_index;

  always_comb begin
    rd_valid_d = read_request;
    rd_zero_d  = rd_zero_q;
    if (read_request) begin
      rd_zero_d = (CW'(read_index) >= count_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      wrapped_q   <= 1'b0;
      triggered_q <= 1'b0;
      cycle_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_zero_q   <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      wrapped_q   <= wrapped_d;
      triggered_q <= triggered_d;
      cycle_q     <= cycle_d;
      rd_valid_q  <= rd_valid_d;
      rd_zero_q   <= rd_zero_d;
    end
  end

  // Read-first RAM: a read colliding with a capture write returns the old word.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
    if (read_request) begin
      rd_word_q <= mem_q[rd_addr];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < EW; gi++) begin : g_rd_mask
      assign read_data[gi] = rd_word_q[gi] & ~rd_zero_q;
    end
  endgenerate

  assign triggered   = triggered_q;
  assign wrapped     = wrapped_q;
  assign entry_count = count_q;
  assign cycle_count = cycle_q;
  assign read_valid  = rd_valid_q;

endmodule
